// File: rtl/warmboot_sequencer.sv
// Sequences an FPGA warm reboot: drain USB traffic, detach from the host, settle the image select, then pulse BOOT.
// Registered outputs track the state entered at each edge; BOOT is terminal until reset.
module warmboot_sequencer #(
   parameter int unsigned QUIET_CYCLES  = 48,
   parameter int unsigned DRAIN_TIMEOUT = 480000,
   parameter int unsigned DETACH_CYCLES = 480000,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic       clk_48mhz,
   input  logic       reset,
   input  logic       boot_req,
   input  logic [1:0] boot_image,
   input  logic       boot_abort,
   input  logic       usb_tx_en,
   output logic       usb_detach,
   output logic       warm_s1,
   output logic       warm_s0,
   output logic       warm_boot,
   output logic       busy
);

   localparam int unsigned MAX_A = (QUIET_CYCLES  > DRAIN_TIMEOUT) ? QUIET_CYCLES  : DRAIN_TIMEOUT;
   localparam int unsigned MAX_B = (DETACH_CYCLES > SETTLE_CYCLES) ? DETACH_CYCLES : SETTLE_CYCLES;
   localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CW    = $clog2(MAX_P) + 1;

   // Exit compares use count-1 so the terminal value never needs an extra bit.
   localparam logic [CW-1:0] QUIET_LAST  = CW'(QUIET_CYCLES  - 1);
   localparam logic [CW-1:0] TMO_LAST    = CW'(DRAIN_TIMEOUT - 1);
   localparam logic [CW-1:0] DETACH_LAST = CW'(DETACH_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      DETACH = 3'd2,
      SETTLE = 3'd3,
      BOOT   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   quiet_q, quiet_d;
   logic [CW-1:0]   tmo_q, tmo_d;
   logic [1:0]      img_q, img_d;
   logic            usb_detach_q, warm_boot_q, busy_q;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   // tmo_q doubles as the phase counter for DETACH and SETTLE.
   always_comb begin
      state_d = state_q;
      quiet_d = quiet_q;
      tmo_d   = tmo_q;
      img_d   = img_q;
      case (state_q)
         IDLE: begin
            if (boot_req) begin
               img_d   = boot_image;
               quiet_d = '0;
               tmo_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            quiet_d = usb_tx_en ? '0 : sat_inc(quiet_q);
            tmo_d   = sat_inc(tmo_q);
            if (boot_abort) begin
               state_d = IDLE;
            end else if ((!usb_tx_en && (quiet_q >= QUIET_LAST)) || (tmo_q >= TMO_LAST)) begin
               state_d = DETACH;
               tmo_d   = '0;
            end
         end
         DETACH: begin
            if (tmo_q >= DETACH_LAST) begin
               state_d = SETTLE;
               tmo_d   = '0;
            end else begin
               tmo_d   = sat_inc(tmo_q);
            end
         end
         SETTLE: begin
            if (tmo_q >= SETTLE_LAST) begin
               state_d = BOOT;
               tmo_d   = '0;
            end else begin
               tmo_d   = sat_inc(tmo_q);
            end
         end
         BOOT: begin
            state_d = BOOT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         quiet_q      <= '0;
         tmo_q        <= '0;
         img_q        <= 2'b00;
         usb_detach_q <= 1'b0;
         warm_boot_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         quiet_q      <= quiet_d;
         tmo_q        <= tmo_d;
         img_q        <= img_d;
         busy_q       <= (state_d != IDLE);
         usb_detach_q <= (state_d == DETACH) || (state_d == SETTLE) || (state_d == BOOT);
         warm_boot_q  <= (state_d == BOOT);
      end
   end

   assign usb_detach = usb_detach_q;
   assign warm_boot  = warm_boot_q;
   assign busy       = busy_q;
   assign warm_s1    = img_q[1];
   assign warm_s0    = img_q[0];

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench for warmboot_sequencer with a per-cycle expected-output scoreboard.
module tb_warmboot_sequencer;

   logic       clk_48mhz = 1'b0;
   logic       reset     = 1'b1;
   logic       boot_req  = 1'b0;
   logic [1:0] boot_image = 2'b00;
   logic       boot_abort = 1'b0;
   logic       usb_tx_en  = 1'b0;
   logic       usb_detach, warm_s1, warm_s0, warm_boot, busy;

   int errors = 0;
   int checks = 0;
   logic [4:0] sb_q[$];

   warmboot_sequencer #(
      .QUIET_CYCLES (4),
      .DRAIN_TIMEOUT(20),
      .DETACH_CYCLES(8),
      .SETTLE_CYCLES(2)
   ) dut (
      .clk_48mhz (clk_48mhz),
      .reset     (reset),
      .boot_req  (boot_req),
      .boot_image(boot_image),
      .boot_abort(boot_abort),
      .usb_tx_en (usb_tx_en),
      .usb_detach(usb_detach),
      .warm_s1   (warm_s1),
      .warm_s0   (warm_s0),
      .warm_boot (warm_boot),
      .busy      (busy)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   // Output vector order: {busy, usb_detach, warm_s1, warm_s0, warm_boot}
   function automatic logic [4:0] outs();
      return {busy, usb_detach, warm_s1, warm_s0, warm_boot};
   endfunction

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rq, input logic [1:0] im, input logic ab, input logic tx,
                       input logic [4:0] ex, input string tag);
      logic [4:0] e;
      @(posedge clk_48mhz);
      #1;
      boot_req   = rq;
      boot_image = im;
      boot_abort = ab;
      usb_tx_en  = tx;
      sb_q.push_back(ex);
      @(negedge clk_48mhz);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, outs(), 5'bxxxxx);
      end else begin
         e = sb_q.pop_front();
         check(tag, outs(), e);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      boot_req = 1'b0; boot_abort = 1'b0; usb_tx_en = 1'b0; boot_image = 2'b00;
      repeat (2) @(posedge clk_48mhz);
      #1 reset = 1'b0;
   endtask

   // id 1: quiet bus, 2: busy bus, 3: single tx burst at cycle 3, 5: ignored inputs during DETACH/SETTLE/BOOT.
   // d/b: first cycle of usb_detach / warm_boot; request at cycle 0 from a freshly reset DUT.
   task automatic scen(input int id, input logic [1:0] img, input int d, input int b, input int n);
      for (int c = 0; c <= n; c++) begin
         logic       rq, ab, tx;
         logic [1:0] im;
         logic [4:0] ex;
         rq = (c == 0) || (id == 5 && (c == 7 || c == 16));
         im = (c == 0) ? img : 2'b11;
         ab = (id == 5) && (c == 9 || c == 13);
         tx = (id == 2) ? 1'b1 : ((id == 3) ? (c == 3) : 1'b0);
         ex = {(c >= 1), (c >= d), ((c >= 1) ? img : 2'b00), (c >= b)};
         step(rq, im, ab, tx, ex, $sformatf("s%0d_c%0d", id, c));
      end
   endtask

   initial begin
      do_reset();
      check("reset_state", outs(), 5'b00000);

      scen(1, 2'b10, 5, 15, 20);
      do_reset();
      scen(2, 2'b01, 21, 31, 35);
      do_reset();
      scen(3, 2'b11, 8, 18, 22);
      do_reset();
      scen(5, 2'b10, 5, 15, 20);

      // Abort at cycle 2; new request at cycle 5 arrives together with an abort and must still start.
      do_reset();
      for (int c = 0; c <= 24; c++) begin
         logic [4:0] ex;
         logic [1:0] s;
         s  = (c >= 6) ? 2'b01 : ((c >= 1) ? 2'b10 : 2'b00);
         ex = {(c == 1 || c == 2 || c >= 6), (c >= 10), s, (c >= 20)};
         step((c == 0 || c == 5), (c == 0) ? 2'b10 : 2'b01, (c == 2 || c == 5), 1'b0, ex,
              $sformatf("abort_c%0d", c));
      end

      // Abort coinciding with the quiet exit cycle wins.
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         step((c == 0), 2'b11, (c == 4), 1'b0, {(c >= 1 && c <= 4), 1'b0, ((c >= 1) ? 2'b11 : 2'b00), 1'b0},
              $sformatf("abort_exit_c%0d", c));
      end

      // Reset mid-DETACH, then again in BOOT; outputs must clear before the next edge.
      do_reset();
      scen(1, 2'b10, 5, 15, 8);
      #1 reset = 1'b1;
      #1 check("rst_detach_async", outs(), 5'b00000);
      #1 reset = 1'b0;
      for (int c = 0; c < 3; c++) step(1'b0, 2'b00, 1'b0, 1'b0, 5'b00000, $sformatf("idle_after_rst1_%0d", c));
      scen(1, 2'b10, 5, 15, 17);
      #1 reset = 1'b1;
      #1 check("rst_boot_async", outs(), 5'b00000);
      #1 reset = 1'b0;
      for (int c = 0; c < 3; c++) step(1'b0, 2'b00, 1'b1, 1'b1, 5'b00000, $sformatf("idle_after_rst2_%0d", c));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
